// File: rtl/mont_conv_pkg.sv
// Shared types and helpers for the normal <-> Montgomery domain converter.
// Also supplies the default Montgomery exponent for a WLM-friendly modulus.
package mont_conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic MODE_TO   = 1'b0;
  localparam logic MODE_FROM = 1'b1;

  // R = 2^(W*ceil(LOGQ/W)) must match the multiplier's word-level reduction depth.
  function automatic int logr_default(input int logq, input int logqh);
    int w;
    w = logq - logqh;
    return w * ((logq + w - 1) / w);
  endfunction

endpackage

// File: rtl/mont_conv_step.sv
// One converter iteration: modular doubling (TO) or modular halving (FROM).
// With bypass set it performs the single conditional subtraction used to pre-reduce [0,2q) inputs.
module mont_conv_step
  import mont_conv_pkg::*;
#(
  parameter int LOGQ = 32
) (
  input  logic [LOGQ:0] x,
  input  logic [LOGQ:0] q,
  input  logic          mode,
  input  logic          bypass,
  output logic [LOGQ:0] x_next
);

  logic [LOGQ+1:0] x_w;
  logic [LOGQ+1:0] q_w;
  logic [LOGQ+1:0] cand;
  logic [LOGQ+1:0] diff;
  logic [LOGQ+1:0] sum;

  assign x_w = {1'b0, x};
  assign q_w = {1'b0, q};

  always_comb begin
    cand   = bypass ? x_w : {x, 1'b0};
    diff   = cand - q_w;
    sum    = x_w + q_w;
    x_next = x;
    // q is odd, so x+q is even whenever x is odd and the shift is exact.
    if (!bypass && mode == MODE_FROM) begin
      x_next = x[0] ? sum[LOGQ+1:1] : x_w[LOGQ+1:1];
    end else if (cand >= q_w) begin
      x_next = diff[LOGQ:0];
    end else begin
      x_next = cand[LOGQ:0];
    end
  end

endmodule

// File: rtl/mont_domain_conv.sv
// Iterative converter: X*R mod q (TO) or X*R^-1 mod q (FROM), R = 2^LOGR,
// q = {qH, W'b0} + 1. One operand in flight; valid/ready on both sides.
module mont_domain_conv
  import mont_conv_pkg::*;
#(
  parameter int LOGQ  = 32,
  parameter int LOGQH = 15,
  parameter int LOGR  = logr_default(LOGQ, LOGQH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LOGQH-1:0] qH,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [LOGQ-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOGQ-1:0]  out_data
);

  localparam int W  = LOGQ - LOGQH;
  localparam int CW = $clog2(LOGR + 1);

  state_e        state_q, state_d;
  logic [LOGQ:0] x_q, x_d;
  logic [LOGQ:0] q_q, q_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LOGQ:0] step_x;

  mont_conv_step #(
    .LOGQ(LOGQ)
  ) u_step (
    .x      (x_q),
    .q      (q_q),
    .mode   (mode_q),
    .bypass (state_q == LOAD),
    .x_next (step_x)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_data  = (state_q == DONE) ? x_q[LOGQ-1:0] : '0;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    q_d     = q_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          x_d     = {1'b0, in_data};
          q_d     = {1'b0, qH, {W{1'b0}}} | {{LOGQ{1'b0}}, 1'b1};
          mode_d  = in_mode;
          state_d = LOAD;
        end
      end
      LOAD: begin
        x_d     = step_x;
        cnt_d   = CW'(LOGR);
        state_d = ITER;
      end
      ITER: begin
        x_d   = step_x;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      q_q     <= '0;
      mode_q  <= MODE_TO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      q_q     <= q_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
